// File: rtl/debug_pkg.sv
// Shared types and constants for the debug dump path.
package debug_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HALT,
        ST_HDR,
        ST_PC,
        ST_REG,
        ST_MEM_ADDR,
        ST_MEM_WAIT,
        ST_MEM,
        ST_TRL,
        ST_DONE
    } dump_state_e;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] FRAME_TRL = 8'h5A;
    localparam int         GPR_COUNT = 32;

    function automatic logic [31:0] mem_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/dump_word_serializer.sv
// Holds one 32-bit word and hands it out MSB-first, one byte
// per valid/ready handshake; a new load overrides any residue.
module dump_word_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [7:0]  data_o,
    output logic        last_o,
    output logic        done_o
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= word_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            if (cnt_q == 2'd3) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= {shift_q[23:0], 8'h00};
                cnt_q   <= cnt_q + 2'd1;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = valid_q ? shift_q[31:24] : 8'h00;
    assign last_o  = (cnt_q == 2'd3);
    assign done_o  = valid_q && ready_i && last_o;

endmodule

// File: rtl/debug_dump_unit.sv
// Freezes the core and streams PC, GPRs and a memory window
// out as a framed byte stream towards the UART transmitter.
module debug_dump_unit
    import debug_pkg::*;
#(
    parameter logic [31:0] MEM_BASE      = 32'h0000_0000,
    parameter int          NUM_MEM_WORDS = 16,
    parameter int          MEM_LAT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_start,
    input  logic [31:0] pc_value,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        debugMode,
    output logic [31:0] DebugAddress,
    input  logic [31:0] mem_data,
    output logic        cpu_halt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dump_busy,
    output logic        dump_done
);

    localparam logic        HAS_MEM   = (NUM_MEM_WORDS != 0);
    localparam logic [31:0] LAST_WORD = 32'(NUM_MEM_WORDS - 1);
    localparam logic [15:0] LAT_LAST  = 16'(MEM_LAT - 1);

    dump_state_e state_q;
    logic        halt_q, dbg_q, busy_q, done_q;
    logic [4:0]  sel_q;
    logic [31:0] addr_q, idx_q;
    logic [15:0] wait_q;
    logic        cvld_q;
    logic [7:0]  cbyte_q;

    logic        ser_load, ser_valid, ser_last, ser_done;
    logic [31:0] ser_word;
    logic [7:0]  ser_data;

    // reg_sel runs one ahead of the word in flight, so the next GPR
    // is already on reg_data when the current word's last byte goes.
    always_comb begin
        ser_load = 1'b0;
        ser_word = reg_data;
        unique case (state_q)
            ST_HDR: begin
                ser_load = cvld_q && tx_ready;
                ser_word = pc_value;
            end
            ST_PC:  ser_load = ser_done;
            ST_REG: ser_load = ser_done && (sel_q != 5'd0);
            ST_MEM_WAIT: begin
                ser_load = (wait_q == LAT_LAST);
                ser_word = mem_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
            dbg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            cvld_q  <= 1'b0;
            cbyte_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (dump_start) begin
                    state_q <= ST_HALT;
                    halt_q  <= 1'b1;
                    dbg_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
                ST_HALT: begin
                    state_q <= ST_HDR;
                    cvld_q  <= 1'b1;
                    cbyte_q <= FRAME_HDR;
                end
                ST_HDR: if (cvld_q && tx_ready) begin
                    cvld_q  <= 1'b0;
                    cbyte_q <= '0;
                    state_q <= ST_PC;
                end
                ST_PC: if (ser_done) begin
                    sel_q   <= 5'd1;
                    state_q <= ST_REG;
                end
                ST_REG: if (ser_done) begin
                    if (sel_q != 5'd0) begin
                        sel_q <= sel_q + 5'd1;
                    end else if (HAS_MEM) begin
                        idx_q   <= '0;
                        state_q <= ST_MEM_ADDR;
                    end else begin
                        cvld_q  <= 1'b1;
                        cbyte_q <= FRAME_TRL;
                        state_q <= ST_TRL;
                    end
                end
                ST_MEM_ADDR: begin
                    addr_q  <= mem_addr(MEM_BASE, idx_q);
                    wait_q  <= '0;
                    state_q <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (wait_q == LAT_LAST) state_q <= ST_MEM;
                    else wait_q <= wait_q + 16'd1;
                end
                ST_MEM: if (ser_done) begin
                    if (idx_q == LAST_WORD) begin
                        cvld_q  <= 1'b1;
                        cbyte_q <= FRAME_TRL;
                        state_q <= ST_TRL;
                    end else begin
                        idx_q   <= idx_q + 32'd1;
                        state_q <= ST_MEM_ADDR;
                    end
                end
                ST_TRL: if (cvld_q && tx_ready) begin
                    cvld_q  <= 1'b0;
                    cbyte_q <= '0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    halt_q  <= 1'b0;
                    dbg_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dump_word_serializer u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .word_i  (ser_word),
        .ready_i (tx_ready),
        .valid_o (ser_valid),
        .data_o  (ser_data),
        .last_o  (ser_last),
        .done_o  (ser_done)
    );

    assign reg_sel      = sel_q;
    assign debugMode    = dbg_q;
    assign DebugAddress = addr_q;
    assign cpu_halt     = halt_q;
    assign dump_busy    = busy_q;
    assign dump_done    = done_q;
    assign tx_valid     = cvld_q | ser_valid;
    assign tx_data      = cvld_q ? cbyte_q : ser_data;

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed + randomized checks of the dump frame against a reference frame builder.
module tb_debug_dump_unit;

    localparam int          LAT1  = 1;
    localparam int          LAT2  = 3;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start2;
    logic [31:0] pc;
    logic [31:0] gpr [32];
    int          rm1, rm2;
    logic        rdy1 = 1'b0, rdy2 = 1'b0;

    logic [4:0]  sel1, sel2;
    logic [31:0] rdata1, rdata2, addr1, addr2;
    logic [31:0] mdata1 = '0, mdata2 = '0;
    logic        dbg1, dbg2, halt1, halt2, txv1, txv2;
    logic        busy1, busy2, done1, done2;
    logic [7:0]  txd1, txd2;

    assign rdata1 = gpr[sel1];
    assign rdata2 = gpr[sel2];

    debug_dump_unit #(.MEM_BASE(32'h0), .NUM_MEM_WORDS(2), .MEM_LAT(LAT1)) dut (
        .clk(clk), .reset(rst), .dump_start(start1), .pc_value(pc),
        .reg_sel(sel1), .reg_data(rdata1), .debugMode(dbg1),
        .DebugAddress(addr1), .mem_data(mdata1), .cpu_halt(halt1),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1),
        .dump_busy(busy1), .dump_done(done1)
    );

    debug_dump_unit #(.MEM_BASE(BASE2), .NUM_MEM_WORDS(2), .MEM_LAT(LAT2)) dut2 (
        .clk(clk), .reset(rst), .dump_start(start2), .pc_value(pc),
        .reg_sel(sel2), .reg_data(rdata2), .debugMode(dbg2),
        .DebugAddress(addr2), .mem_data(mdata2), .cpu_halt(halt2),
        .tx_data(txd2), .tx_valid(txv2), .tx_ready(rdy2),
        .dump_busy(busy2), .dump_done(done2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hDEAD_BEEF;
        if (a == 32'h4) return 32'h1234_5678;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: a word is readable once its address has been stable for
    // LAT cycles; dut2's window closes one cycle later to pin timing.
    int age1 = 1000, age2 = 1000;
    logic [31:0] last1 = '0, last2 = '0;
    always @(negedge clk) begin
        age1   <= (addr1 !== last1) ? 0 : age1 + 1;
        last1  <= addr1;
        mdata1 <= ((((addr1 !== last1) ? 0 : age1 + 1)) >= LAT1 - 1)
                  ? mem_word(addr1) : ~mem_word(addr1);
        age2   <= (addr2 !== last2) ? 0 : age2 + 1;
        last2  <= addr2;
        mdata2 <= ((((addr2 !== last2) ? 0 : age2 + 1)) == LAT2 - 1)
                  ? mem_word(addr2) : ~mem_word(addr2);
        rdy1   <= (rm1 == 1) || (rm1 == 2 && $urandom_range(0, 9) < 3);
        rdy2   <= (rm2 == 1) || (rm2 == 2 && $urandom_range(0, 9) < 3);
    end

    logic [7:0]  q1 [$], q2 [$];
    logic [31:0] a2 [$];
    logic [31:0] prev_a2 = '0;
    int   dcnt1 = 0, dcnt2 = 0, unstable = 0, halt_viol = 0;
    logic pend1 = 1'b0, pend2 = 1'b0;
    logic [7:0] pd1 = '0, pd2 = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (txv1 && rdy1) q1.push_back(txd1);
            if (txv2 && rdy2) q2.push_back(txd2);
            if (done1) dcnt1 <= dcnt1 + 1;
            if (done2) dcnt2 <= dcnt2 + 1;
            if ((pend1 && (!txv1 || txd1 !== pd1)) ||
                (pend2 && (!txv2 || txd2 !== pd2)))
                unstable <= unstable + 1;
            if ((txv1 && !halt1) || (txv2 && !halt2))
                halt_viol <= halt_viol + 1;
            if (dbg2 && addr2 !== prev_a2) a2.push_back(addr2);
        end
        prev_a2 <= addr2;
        pend1   <= !rst && txv1 && !rdy1;
        pend2   <= !rst && txv2 && !rdy2;
        pd1     <= txd1;
        pd2     <= txd2;
    end

    int checks = 0, failures = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int s = 3; s >= 0; s--) exp_q.push_back(8'(w >> (8 * s)));
    endtask

    task automatic build(input logic [31:0] pcv, input logic [31:0] base,
                         input int nw);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        push_word(pcv);
        for (int i = 0; i < 32; i++) push_word(gpr[i]);
        for (int i = 0; i < nw; i++) push_word(mem_word(base + 32'(4 * i)));
        exp_q.push_back(8'h5A);
    endtask

    task automatic cmp_frame(input string tag, input int d, input int b);
        int n, bad, first;
        logic [7:0] got, fb_got, fb_exp;
        n = (d == 1) ? q1.size() - b : q2.size() - b;
        chk({tag, " length"}, 32'(n), 32'(exp_q.size()));
        bad = 0;
        first = -1;
        fb_got = '0;
        fb_exp = '0;
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            got = (d == 1) ? q1[b + k] : q2[b + k];
            if (got !== exp_q[k]) begin
                bad++;
                if (first < 0) begin
                    first = k;
                    fb_got = got;
                    fb_exp = exp_q[k];
                end
            end
        end
        chk({tag, " bad bytes"}, 32'(bad), 32'd0);
        if (first >= 0) chk({tag, " first bad byte"}, 32'(fb_got), 32'(fb_exp));
    endtask

    task automatic wait_done(input string tag, input int d, input int base);
        int t = 0;
        while (((d == 1) ? dcnt1 : dcnt2) <= base && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk({tag, " timeout"}, 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bytes(input int b, input int n);
        int t = 0;
        while (q1.size() - b < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("byte wait timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    logic [7:0] head [13];
    logic [7:0] tail [9];
    int b, d0;

    initial begin
        head = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
        tail = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56,
                 8'h78, 8'h5A};
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        rm1 = 1; rm2 = 0;
        pc = 32'h0000_0040;
        for (int i = 0; i < 32; i++) gpr[i] = 32'(i) * 32'h0101_0101;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", 32'(txv1), 32'd0);
        chk("rst tx_data", 32'(txd1), 32'd0);
        chk("rst cpu_halt", 32'(halt1), 32'd0);
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst debugMode", 32'(dbg1), 32'd0);
        chk("rst reg_sel", 32'(sel1), 32'd0);
        chk("rst DebugAddress", addr1, 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle bytes", 32'(q1.size()), 32'd0);
        chk("idle tx_valid", 32'(txv1), 32'd0);
        chk("idle cpu_halt", 32'(halt1), 32'd0);
        chk("idle busy", 32'(busy1), 32'd0);

        // Full frame with the documented register/memory pattern
        b = q1.size(); d0 = dcnt1;
        pulse1();
        chk("start halt", 32'(halt1), 32'd1);
        chk("start busy", 32'(busy1), 32'd1);
        chk("start debugMode", 32'(dbg1), 32'd1);
        wait_done("t2", 1, d0);
        build(pc, 32'h0, 2);
        cmp_frame("t2", 1, b);
        for (int k = 0; k < 13; k++)
            if (q1.size() > b + k) chk("t2 head", 32'(q1[b + k]), 32'(head[k]));
        for (int k = 0; k < 9; k++)
            if (q1.size() >= b + 142) chk("t2 tail", 32'(q1[b + 133 + k]), 32'(tail[k]));
        chk("t2 done pulses", 32'(dcnt1 - d0), 32'd1);
        chk("t2 halt released", 32'(halt1), 32'd0);
        chk("t2 busy released", 32'(busy1), 32'd0);
        chk("t2 debugMode released", 32'(dbg1), 32'd0);

        // Random data, sparse ready
        for (int i = 0; i < 32; i++) gpr[i] = $urandom;
        pc = $urandom;
        rm1 = 2;
        b = q1.size(); d0 = dcnt1;
        pulse1();
        wait_done("t3", 1, d0);
        build(pc, 32'h0, 2);
        cmp_frame("t3", 1, b);
        chk("t3 tx_data stable", 32'(unstable), 32'd0);

        // Second start mid-frame is dropped
        rm1 = 1;
        b = q1.size(); d0 = dcnt1;
        pulse1();
        wait_bytes(b, 50);
        pulse1();
        wait_done("t5", 1, d0);
        repeat (10) @(negedge clk);
        build(pc, 32'h0, 2);
        cmp_frame("t5", 1, b);
        chk("t5 done pulses", 32'(dcnt1 - d0), 32'd1);
        chk("t5 busy after", 32'(busy1), 32'd0);

        // Reset mid-frame, then a clean dump
        rm1 = 2;
        b = q1.size();
        pulse1();
        wait_bytes(b, 70);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 tx_valid", 32'(txv1), 32'd0);
        chk("t6 cpu_halt", 32'(halt1), 32'd0);
        chk("t6 busy", 32'(busy1), 32'd0);
        chk("t6 debugMode", 32'(dbg1), 32'd0);
        chk("t6 reg_sel", 32'(sel1), 32'd0);
        chk("t6 tx_data", 32'(txd1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) gpr[i] = $urandom;
        pc = $urandom;
        b = q1.size(); d0 = dcnt1;
        pulse1();
        wait_done("t6", 1, d0);
        build(pc, 32'h0, 2);
        cmp_frame("t6", 1, b);

        // Wrapping address window, 3-cycle memory
        rm1 = 0; rm2 = 2;
        b = q2.size(); d0 = dcnt2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done("t4", 2, d0);
        build(pc, BASE2, 2);
        cmp_frame("t4", 2, b);
        chk("t4 addr count", 32'(a2.size()), 32'd2);
        if (a2.size() >= 2) begin
            chk("t4 addr0", a2[0], 32'hFFFF_FFFC);
            chk("t4 addr1", a2[1], 32'h0000_0000);
        end
        chk("t4 done pulses", 32'(dcnt2 - d0), 32'd1);
        chk("tx_data stable", 32'(unstable), 32'd0);
        chk("halt during tx", 32'(halt_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
